// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor and related blocks.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_sup_state_t;

    localparam int LOSS_CNT_W = 8;

    // Largest of three cycle counts; sizes the shared state timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        if (c > m) begin
            m = c;
        end
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous status levels.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a full cycle to resolve.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset and lock supervisor on the reference clock.
// Drives the PLL reset, waits for a continuous lock before releasing the
// downstream reset, retries on lock timeout and latches a failure once the
// retries run out.
// Optional build macro PLL_LOCK_SUPERVISOR_LOSS_CNT_EN: when defined, an
// 8-bit saturating lock-loss counter drives loss_cnt; otherwise loss_cnt is 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PLL_RST   | PLL held in reset for RST_CYCLES cycles
// WAIT_LOCK | PLL released, waiting up to LOCK_TIMEOUT cycles for lock
// SETTLE    | lock seen, must stay continuous for SETTLE_CYCLES cycles
// RUN       | lock stable, downstream reset released
// FAIL      | retries exhausted, PLL held in reset until rst
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 50,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic                                                    refclk,
    input  logic                                                    rst,
    input  logic                                                    pll_locked,
    output logic                                                    pll_rst,
    output logic                                                    sys_rst,
    output logic                                                    lock_ok,
    output logic                                                    fail,
    output logic [((MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1)-1:0] retry_cnt,
    output logic [LOSS_CNT_W-1:0]                                   loss_cnt
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY);

    pll_sup_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, sys_rst_q, lock_ok_q, fail_q;
    logic               locked_s;

    sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    // Next-state, shared timer and retry bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;

        unique case (state_q)
            PLL_RST: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A lock arriving on the timeout cycle still wins.
                if (locked_s) begin
                    state_d = SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_LAST) begin
                        state_d = FAIL;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = PLL_RST;
                    end
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Any drop, including on the final count, restarts the wait.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = PLL_RST;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State, timer and outputs; outputs are decoded from the next state so
    // they move on the same edge as the state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == PLL_RST) || (state_d == FAIL);
            sys_rst_q <= (state_d != RUN);
            lock_ok_q <= (state_d == RUN);
            fail_q    <= (state_d == FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign lock_ok   = lock_ok_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    logic                  loss_evt;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    assign loss_evt = (state_q == RUN) && !locked_s;

    // Saturating count of lock-loss events seen while running.
    always_comb begin
        loss_d = loss_q;
        if (loss_evt && (loss_q != {LOSS_CNT_W{1'b1}})) begin
            loss_d = loss_q + LOSS_CNT_W'(1);
        end
    end

    // Lock-loss counter register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Reset and lock supervisor for the PLL clocking stage, running on the 50 MHz reference clock directly upstream of the PLL. It drives the PLL reset, synchronises the PLL `locked` output, and requires a continuous lock before releasing the design-wide reset request. It retries on lock timeout, re-locks after lock loss, and reports a sticky failure once retries are exhausted.

## Interface

Parameters:
- `RST_CYCLES`, 50: PLL reset pulse width in refclk cycles, 1 µs at 50 MHz; must be ≥1.
- `LOCK_TIMEOUT`, 50000: cycles to wait for lock per attempt, 1 ms; must be ≥1.
- `SETTLE_CYCLES`, 1024: cycles of continuous lock required before release; must be ≥1.
- `MAX_RETRY`, 3: re-attempts after the first attempt before failing.

Ports:
- `refclk`, in, 1: 50 MHz reference clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `pll_locked`, in, 1: PLL locked output; asynchronous to refclk.
- `pll_rst`, out, 1: reset to the PLL, active-high.
- `sys_rst`, out, 1: downstream reset request, active-high.
- `lock_ok`, out, 1: high in RUN only.
- `fail`, out, 1: sticky; retries exhausted.
- `retry_cnt`, out, `$clog2(MAX_RETRY+1)`: retries used in the current acquisition.
- `loss_cnt`, out, 8: lock-loss events, saturates at 255.

## Operation

- `pll_locked` passes through a 2-FF synchroniser to produce `locked_s`. Only `locked_s` is used internally.
- FSM states are PLL_RST, WAIT_LOCK, SETTLE, RUN and FAIL. One shared cycle counter is cleared on every state change.
- PLL_RST:
  - Outputs: `pll_rst`=1, `sys_rst`=1.
  - The counter increments each cycle; at RST_CYCLES-1 the FSM moves to WAIT_LOCK.
- WAIT_LOCK:
  - Outputs: `pll_rst`=0, `sys_rst`=1.
  - If `locked_s`=1, go to SETTLE.
  - Otherwise, at count LOCK_TIMEOUT-1: if `retry_cnt`==MAX_RETRY, go to FAIL; else increment `retry_cnt` and go to PLL_RST.
- SETTLE:
  - If `locked_s`=0, go to WAIT_LOCK; the timeout restarts and `retry_cnt` is unchanged.
  - At count SETTLE_CYCLES-1 with `locked_s`=1, go to RUN.
- RUN:
  - Outputs: `sys_rst`=0, `lock_ok`=1. `retry_cnt` is cleared on entry.
  - If `locked_s`=0, increment `loss_cnt` (saturating) and go to PLL_RST.
- FAIL:
  - Outputs: `pll_rst`=1, `sys_rst`=1, `fail`=1.
  - Exit only via `rst`.
- Reset values: state PLL_RST, `pll_rst`=1, `sys_rst`=1, `lock_ok`=0, `fail`=0, `retry_cnt`=0, `loss_cnt`=0, counter 0, synchroniser flops 0.
- Priorities:
  - `rst` beats everything, including mid-sequence and in FAIL.
  - In WAIT_LOCK, lock beats timeout in the same cycle: the FSM goes to SETTLE and `retry_cnt` is unchanged.
  - In SETTLE, a lock drop on the final count goes to WAIT_LOCK.
- Counter width is `$clog2` of the maximum of the three cycle parameters. Compares are equality; no wrap is reachable.

## Timing

- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- `pll_rst` pulse: exactly RST_CYCLES cycles, beginning at the first edge after `rst` deasserts or on entry from RUN or WAIT_LOCK.
- Sampling latency: an edge on `pll_locked` is first seen in `locked_s` after 2 edges. The FSM reacts on the 3rd edge.
- Release: `sys_rst` falls 2 + SETTLE_CYCLES + 1 edges after a clean `pll_locked` rise in WAIT_LOCK.
- Lock loss: `sys_rst` rises on the 3rd edge after `pll_locked` falls in RUN.
- Worst case to FAIL: (MAX_RETRY+1)·(RST_CYCLES+LOCK_TIMEOUT) cycles after reset.

## Configuration

- Macro: `PLL_LOCK_SUPERVISOR_LOSS_CNT_EN`.
- Defined: the 8-bit saturating lock-loss counter is synthesised and drives `loss_cnt`.
- Undefined: there is no counter logic and `loss_cnt` is tied to 8'd0. All other behaviour is identical.

## Structure

- Shared package `pll_sup_pkg` holds:
  - the state enum `pll_sup_state_t` (PLL_RST, WAIT_LOCK, SETTLE, RUN, FAIL);
  - the `LOSS_CNT_W`=8 constant;
  - a `max3` function used for counter sizing.
- Sub-module `sync_2ff`, a generic 1-bit two-flop synchroniser with synchronous active-high reset, is reused for other async status bits.

## Test plan

All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=16, SETTLE_CYCLES=8, MAX_RETRY=2.
- Clean lock: `pll_locked` rises 3 cycles into WAIT_LOCK and holds → `pll_rst` high exactly 4 cycles; `sys_rst` falls 11 edges after the rise; `lock_ok`=1; `retry_cnt`=0.
- Never locks: `pll_locked`=0 throughout → three 4-cycle `pll_rst` pulses, `retry_cnt` steps 1, 2, then `fail`=1 after 60 cycles with `pll_rst`=1 held; `rst` clears all.
- Settle glitch: `pll_locked` low for 2 cycles at settle count 5 → return to WAIT_LOCK; `sys_rst` falls 11 edges after the re-rise.
- Lock loss in RUN: `pll_locked` falls → `sys_rst`=1 on the 3rd edge, 4-cycle `pll_rst` pulse, `loss_cnt`=1; relock returns to RUN. Repeat 256 times → `loss_cnt`=255; with the macro undefined, `loss_cnt`=0.
- Reset mid-SETTLE: assert `rst` for 1 cycle → next edge shows `pll_rst`=1, `sys_rst`=1, `retry_cnt`=0, `loss_cnt`=0, state PLL_RST.
- Lock on timeout cycle: `locked_s` goes high exactly at count 15 of WAIT_LOCK → go to SETTLE with `retry_cnt` unchanged and no `pll_rst` pulse.
